cla_mp_sequencer: RTL and testbench
===================================

Name: cla_mp_sequencer

Overview:
- Word-serial multi-precision add/subtract controller that drives a WIDTH-bit carry-lookahead slice once per accepted operand word.
- Chains the carry between words to build WORDS*WIDTH-bit results, LSW first.
- Sits between a host that streams operand words and a consumer that drains result words. Both sides use valid/ready handshakes.
- Reports final carry-out and signed overflow.

Parameters:
- WIDTH, 16, slice width in bits (bits per operand/result word).
- WORDS, 4, number of words per operation (total operand width WIDTH*WORDS); legal range 1..256.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request new operation; sampled only in IDLE
- op  input  1  0 = add, 1 = subtract (a - b); sampled with start
- busy  output  1  high whenever state != IDLE
- in_valid  input  1  a_word/b_word valid
- in_ready  output  1  sequencer accepts operand word this cycle
- a_word  input  WIDTH  operand A word, LSW first
- b_word  input  WIDTH  operand B word, LSW first
- out_valid  output  1  sum_word valid
- out_ready  input  1  consumer accepts sum_word
- sum_word  output  WIDTH  result word, LSW first
- out_last  output  1  qualifies the final result word
- cout  output  1  final carry out (sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow of full-width result
- done  output  1  one-cycle pulse, operation complete

Behaviour:
- Reset: the synchronous rst drives state to IDLE. It also clears word count, carry register, busy, in_ready, out_valid, out_last, sum_word, cout, ovf and done, all to 0. Reset mid-operation aborts it: no done pulse, and partial results are discarded.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN: when start=1.
  - Latch op.
  - Set carry register = op (carry-in 1 for subtract).
  - Set word count = 0; clear cout and ovf.
  - start is ignored in RUN/DRAIN.
- RUN:
  - in_ready = !out_valid || out_ready (single-entry output register; full throughput).
  - On in_valid && in_ready:
    - Compute {c, s} = a_word + (b_word XOR {WIDTH{op}}) + carry; the add is WIDTH+1 bits wide.
    - Register s into sum_word and set out_valid = 1.
    - Set out_last = (count == WORDS-1).
    - Set carry = c; increment count.
  - Latency: a word accepted at cycle N appears on sum_word at N+1.
- Final word accepted (count == WORDS-1):
  - Register cout = c.
  - Register ovf = (a_msb == b'_msb) && (s_msb != a_msb), where b' is the possibly inverted b_word.
  - Go to DRAIN.
- DRAIN: in_ready = 0. When out_valid && out_ready (the last word), clear out_valid and out_last, and go to IDLE. done = 1 and busy = 0 in the cycle after that handshake.
- done: high for exactly one cycle. A start in the done cycle is accepted, giving back-to-back operations.
- Output register: when out_valid && !out_ready, sum_word, out_last and out_valid hold stable. out_valid drops only on handshake with no new word loaded in that cycle.
- Sticky flags: cout and ovf hold from the final word until the next accepted start.
- in_valid gaps: allowed, with no state change.
- WORDS = 1: the first accepted word is also last; out_last = 1 on it.
- Count: ceil(log2(WORDS+1)) bits; no wrap within an operation.

Test Plan (WIDTH=16, WORDS=4):
- Basic add, A=0x0000_0000_0000_FFFF, B=0x1, out_ready=1 -> sum words 0x0000, 0x0001, 0x0000, 0x0000 on four consecutive cycles; out_last on the 4th; cout=0, ovf=0; done one cycle after the last handshake.
- Full carry ripple, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 -> four words 0x0000; cout=1, ovf=0.
- Subtract, op=1:
  - 0 - 1 -> four words 0xFFFF; cout=0, ovf=0.
  - 0x8000_0000_0000_0000 - 1 -> 0xFFFF, 0xFFFF, 0xFFFF, 0x7FFF; cout=1, ovf=1.
  - 0x7FFF_FFFF_FFFF_FFFF + 1 (add) -> ovf=1.
- Backpressure: out_ready=0 for 3 cycles after the 2nd result word -> in_ready=0 while out_valid=1, sum_word stable; on release the remaining words arrive in order and the final sum is correct.
- Reset at RUN with 2 words accepted -> next cycle busy=0, out_valid=0, no done; the following add 0x1+0x1 returns 0x0002, 0, 0, 0.
- start pulsed during RUN is ignored (op unchanged). in_valid deasserted for 2 cycles mid-op produces identical results. start held during the done cycle begins the next operation immediately, with the flags cleared.

Source files
------------

// File: rtl/cla_mp_sequencer.sv
// cla_mp_sequencer
// ----------------
// Word-serial multi-precision add/subtract controller. It accepts one
// operand word pair per handshake, least-significant word first. It drives
// a WIDTH-bit add slice and chains the carry from word to word, so that
// WORDS words form one WORDS*WIDTH-bit result. For subtraction, b is
// inverted and the carry-in is seeded with 1 (a + ~b + 1).
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start, op           begin an operation (0 = add, 1 = a - b), IDLE only
//   busy                high while an operation is in progress
//   in_valid/in_ready   operand handshake for a_word / b_word
//   out_valid/out_ready result handshake for sum_word / out_last
//   cout, ovf           final carry-out (1 = no borrow when subtracting) and
//                       signed overflow; both hold until the next start
//   done                one-cycle pulse after the last result word drains
module cla_mp_sequencer #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_word,
  output logic             out_last,
  output logic             cout,
  output logic             ovf,
  output logic             done
);

  // The count can reach WORDS, so it is sized to hold WORDS itself.
  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic             carry_reg;
  logic             op_reg;
  logic             out_valid_reg;
  logic             out_last_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic             done_reg;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   slice_sum;
  logic             accept;
  logic             is_last;
  logic             out_hs;
  logic             ovf_next;

  // Subtraction is a + ~b + 1; the +1 comes from the seeded carry register.
  assign b_eff     = b_word ^ {WIDTH{op_reg}};
  assign slice_sum = {1'b0, a_word} + {1'b0, b_eff} + {{WIDTH{1'b0}}, carry_reg};

  // The output register holds a single word. A new word can enter in the same
  // cycle that the consumer takes the old one, so throughput stays at one word
  // per cycle.
  assign in_ready = (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_last  = (count_reg == LAST_IDX);
  assign out_hs   = out_valid_reg && out_ready;

  // Signed overflow: both addends have the same sign, but the result sign differs.
  assign ovf_next = (a_word[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (slice_sum[WIDTH-1] != a_word[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      carry_reg     <= 1'b0;
      op_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg    <= op;
            carry_reg <= op;
            count_reg <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            sum_reg       <= slice_sum[WIDTH-1:0];
            out_valid_reg <= 1'b1;
            out_last_reg  <= is_last;
            carry_reg     <= slice_sum[WIDTH];
            count_reg     <= count_reg + CW'(1);
            if (is_last) begin
              cout_reg  <= slice_sum[WIDTH];
              ovf_reg   <= ovf_next;
              state_reg <= DRAIN;
            end
          end else if (out_hs) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
          end
        end
        DRAIN: begin
          // Only the final word remains. Its handshake ends the operation.
          if (out_hs) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign sum_word  = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Self-checking bench for cla_mp_sequencer (WIDTH=16, WORDS=4).
// The reference works on whole 64-bit operands. The unsigned result and carry
// come from a 65-bit add. Overflow is found by checking whether the exact signed
// result fits in 64 bits. The bench tracks words in and out as two counters.
module tb_cla_mp_sequencer;
  localparam int WIDTH = 16;
  localparam int WORDS = 4;
  localparam int TOTAL = WIDTH * WORDS;

  logic             clk = 1'b0;
  logic             rst, start, op, busy, in_valid, in_ready;
  logic             out_valid, out_ready, out_last, cout, ovf, done;
  logic [WIDTH-1:0] a_word, b_word, sum_word;

  int n_checks = 0;
  int n_errors = 0;

  logic [TOTAL-1:0] got_res;
  logic             got_cout, got_ovf;

  always #5 clk = ~clk;

  cla_mp_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_word(a_word), .b_word(b_word),
    .out_valid(out_valid), .out_ready(out_ready), .sum_word(sum_word),
    .out_last(out_last), .cout(cout), .ovf(ovf), .done(done)
  );

  task automatic chk(input string name, input logic [TOTAL+1:0] got, input logic [TOTAL+1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Returns {ovf, cout, result[63:0]}.
  function automatic logic [TOTAL+1:0] model(input bit sub, input logic [TOTAL-1:0] a,
                                             input logic [TOTAL-1:0] b);
    logic [TOTAL:0]          full;
    logic signed [TOTAL+1:0] sa, sb, exact;
    bit                      ov;
    if (sub) full = {1'b0, a} + {1'b0, ~b} + 1;
    else     full = {1'b0, a} + {1'b0, b};
    sa = {{2{a[TOTAL-1]}}, a};
    sb = {{2{b[TOTAL-1]}}, b};
    exact = sub ? (sa - sb) : (sa + sb);
    ov = (exact > $signed({3'b000, {(TOTAL-1){1'b1}}})) ||
         (exact < -$signed({3'b001, {(TOTAL-1){1'b0}}}));
    return {ov, full};
  endfunction

  // This task assumes it is entered on a negedge with the DUT idle or pulsing done.
  // It leaves on the negedge where done is expected.
  task automatic run_op(input bit op_i, input logic [TOTAL-1:0] a, input logic [TOTAL-1:0] b,
                        input int gap_pct, input int stall_pct, input bit bp_mode,
                        input bit noise_start);
    logic [TOTAL+1:0] m;
    int  n_in, n_out, bp_cnt, idx;
    bit  exp_ov, exp_ir, acc, hs, finished;
    m = model(op_i, a, b);
    n_in = 0; n_out = 0; bp_cnt = 0; finished = 0; got_res = '0;
    start = 1'b1; op = op_i; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("cout_cleared", cout, 0);
    chk("ovf_cleared", ovf, 0);
    chk("done_single_cycle", done, 0);
    chk("out_valid_at_start", out_valid, 0);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      exp_ov = (n_in > n_out);
      idx = (n_in < WORDS) ? n_in : 0;
      in_valid = (n_in < WORDS) && ($urandom_range(99) >= gap_pct);
      a_word = in_valid ? a[idx*WIDTH +: WIDTH] : WIDTH'($urandom);
      b_word = in_valid ? b[idx*WIDTH +: WIDTH] : WIDTH'($urandom);
      out_ready = ($urandom_range(99) >= stall_pct);
      if (bp_mode && n_in == 2 && n_out == 1 && bp_cnt < 3) begin
        out_ready = 1'b0;
        bp_cnt++;
      end
      if (noise_start) begin
        start = 1'($urandom_range(1));
        op = ~op_i;
      end
      #1;
      exp_ir = (n_in < WORDS) && (!exp_ov || out_ready);
      chk("in_ready", in_ready, exp_ir);
      acc = in_valid && exp_ir;
      hs  = exp_ov && out_ready;
      if (hs) got_res[n_out*WIDTH +: WIDTH] = sum_word;
      @(posedge clk); @(negedge clk);
      if (acc) n_in++;
      if (hs) n_out++;
      if (n_out == WORDS) begin
        finished = 1;
        chk("done_pulse", done, 1);
        chk("busy_in_done_cycle", busy, 0);
        chk("out_valid_after_drain", out_valid, 0);
        chk("cout", cout, m[TOTAL]);
        chk("ovf", ovf, m[TOTAL+1]);
        chk("result", got_res, m[TOTAL-1:0]);
        got_cout = cout;
        got_ovf  = ovf;
      end else begin
        chk("done_early", done, 0);
        chk("busy_running", busy, 1);
        chk("out_valid", out_valid, n_in > n_out);
        if (n_in > n_out) begin
          chk("sum_word", sum_word, m[n_out*WIDTH +: WIDTH]);
          chk("out_last", out_last, n_out == WORDS - 1);
        end
      end
    end
    chk("op_completed_in_budget", finished, 1);
    start = 1'b0; in_valid = 1'b0; op = 1'b0;
  endtask

  initial begin
    logic [TOTAL+1:0] mp;
    rst = 1'b1; start = 1'b0; op = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a_word = '0; b_word = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sum_word", sum_word, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_done", done, 0);

    // Fix the reference model itself with hand-computed values.
    mp = model(1'b1, 64'h8000_0000_0000_0000, 64'h1);
    chk("model_pin_sub", mp, {2'b11, 64'h7FFF_FFFF_FFFF_FFFF});
    mp = model(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
    chk("model_pin_add", mp, {2'b10, 64'h8000_0000_0000_0000});

    // These directed cases run back to back. Each start falls in the previous done cycle.
    run_op(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 0, 0, 1'b0, 1'b0);
    chk("lit_basic_add", {got_ovf, got_cout, got_res}, {2'b00, 64'h0000_0000_0001_0000});
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 1'b0, 1'b0);
    chk("lit_ripple", {got_ovf, got_cout, got_res}, {2'b01, 64'h0});
    run_op(1'b1, 64'h0, 64'h1, 0, 0, 1'b0, 1'b0);
    chk("lit_sub_0_1", {got_ovf, got_cout, got_res}, {2'b00, 64'hFFFF_FFFF_FFFF_FFFF});
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'h1, 0, 0, 1'b0, 1'b0);
    chk("lit_sub_min", {got_ovf, got_cout, got_res}, {2'b11, 64'h7FFF_FFFF_FFFF_FFFF});
    run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 1'b0, 1'b0);
    chk("lit_add_max", {got_ovf, got_cout, got_res}, {2'b10, 64'h8000_0000_0000_0000});
    run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 0, 0, 1'b1, 1'b0);
    chk("lit_backpressure", {got_ovf, got_cout, got_res}, {2'b00, 64'h2345_6789_ABCD_F001});
    run_op(1'b1, 64'h8000_0000_0000_0000, 64'h1, 50, 0, 1'b0, 1'b0);
    chk("lit_gaps", {got_ovf, got_cout, got_res}, {2'b11, 64'h7FFF_FFFF_FFFF_FFFF});
    run_op(1'b1, 64'h0, 64'h1, 30, 30, 1'b0, 1'b1);
    chk("lit_start_noise", {got_ovf, got_cout, got_res}, {2'b00, 64'hFFFF_FFFF_FFFF_FFFF});

    // A reset after two accepted words aborts the operation without a done pulse.
    @(posedge clk); @(negedge clk);
    start = 1'b1; op = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a_word = 16'hABCD; b_word = 16'h1234;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0);
    chk("abort_sum_word", sum_word, 0);
    @(posedge clk); @(negedge clk);
    chk("abort_no_late_done", done, 0);
    run_op(1'b0, 64'h1, 64'h1, 0, 0, 1'b0, 1'b0);
    chk("lit_after_abort", {got_ovf, got_cout, got_res}, {2'b00, 64'h2});

    // Random operations, each started back to back in the previous done cycle.
    for (int t = 0; t < 40; t++) begin
      logic [TOTAL-1:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 5 == 0) ra[TOTAL-1] = ~rb[TOTAL-1];
      run_op(1'($urandom_range(1)), ra, rb, $urandom_range(40), $urandom_range(40),
             1'b0, 1'($urandom_range(1)));
    end

    @(posedge clk); @(negedge clk);
    chk("final_done_dropped", done, 0);
    chk("final_idle", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
